// File: rtl/proc_run_pkg.sv
// Shared definitions for the program-run controller: run state encoding,
// PC width and the default watchdog limit.
package proc_run_pkg;

  localparam int unsigned PC_W           = 32'd64;
  localparam int unsigned DEF_WDOG_LIMIT = 32'd255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } run_state_e;

endpackage : proc_run_pkg

// File: rtl/run_watchdog.sv
// Run-cycle counter for the program-run controller. Clears on request,
// counts while enabled, saturates at all-ones and flags the cycle on
// which the count reaches LIMIT-1 (the last run cycle allowed).
module run_watchdog #(
  parameter int unsigned W     = 32'd16,
  parameter int unsigned LIMIT = 32'd255
) (
  input  logic         CLK,
  input  logic         resetl,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         expire
);

  localparam logic [W-1:0] EXP_VAL = W'(LIMIT - 32'd1);
  localparam logic [W-1:0] SAT_VAL = {W{1'b1}};

  // Expire is decoded from the registered count, so it is glitch-free.
  assign expire = (count == EXP_VAL);

  // Saturating cycle counter with synchronous clear.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      count <= {W{1'b0}};
    end else if (clear) begin
      count <= {W{1'b0}};
    end else if (enable && (count != SAT_VAL)) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule : run_watchdog

// File: rtl/proc_run_controller.sv
// Sequences one program run on the single-cycle core: holds the core in
// reset, releases it at the latched start PC, waits for currentpc to reach
// the end address, captures MemtoRegOut and compares it with the expected
// value. A watchdog bounds every run.
// Optional build macro PROC_RUN_STALL_DETECT_EN adds a self-branch hang
// detector (currentpc constant for 4 RUN cycles) and the 'stall' output.
module proc_run_controller
  import proc_run_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 32'd2,
  parameter int unsigned WDOG_W     = 32'd16,
  parameter int unsigned WDOG_LIMIT = DEF_WDOG_LIMIT
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              start,
  input  logic              abort,
  input  logic [PC_W-1:0]   start_pc_in,
  input  logic [PC_W-1:0]   end_pc_in,
  input  logic [PC_W-1:0]   expected_in,
  input  logic [PC_W-1:0]   currentpc,
  input  logic [PC_W-1:0]   memtoreg_in,
  output logic              core_resetl,
  output logic [PC_W-1:0]   core_startpc,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [PC_W-1:0]   result,
`ifdef PROC_RUN_STALL_DETECT_EN
  output logic              stall,
`endif
  output logic [WDOG_W-1:0] cycles
);

  localparam int unsigned   RC_W    = (RST_CYCLES > 32'd1) ? $clog2(RST_CYCLES) : 32'd1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 32'd1);

  run_state_e       state_r;
  logic [RC_W-1:0]  rst_cnt_r;
  logic [PC_W-1:0]  end_pc_r;
  logic [PC_W-1:0]  exp_r;
  logic             end_hit_s;
  logic             start_ok_s;
  logic             wd_enable_s;
  logic             wd_expire_s;
  logic             stall_hit_s;

  assign end_hit_s = (currentpc >= end_pc_r);

`ifdef PROC_RUN_STALL_DETECT_EN
  logic [PC_W-1:0] prev_pc_r;
  logic            pc_vld_r;
  logic [1:0]      same_cnt_r;

  // Fourth consecutive RUN cycle with an unchanged PC is the third repeat.
  assign stall_hit_s = pc_vld_r && (currentpc == prev_pc_r) && (same_cnt_r == 2'd2);

  // PC history: counts consecutive RUN cycles in which the PC repeated.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      prev_pc_r  <= {PC_W{1'b0}};
      pc_vld_r   <= 1'b0;
      same_cnt_r <= 2'd0;
    end else if (state_r == ST_RUN) begin
      prev_pc_r <= currentpc;
      pc_vld_r  <= 1'b1;
      if (pc_vld_r && (currentpc == prev_pc_r)) begin
        same_cnt_r <= (same_cnt_r == 2'd3) ? 2'd3 : same_cnt_r + 2'd1;
      end else begin
        same_cnt_r <= 2'd0;
      end
    end else begin
      prev_pc_r  <= prev_pc_r;
      pc_vld_r   <= 1'b0;
      same_cnt_r <= 2'd0;
    end
  end
`else
  assign stall_hit_s = 1'b0;
`endif

  // Watchdog control: clear on an accepted start, count RUN cycles that do not end the run.
  always_comb begin
    start_ok_s  = 1'b0;
    wd_enable_s = 1'b0;
    if (((state_r == ST_IDLE) || (state_r == ST_DONE)) && start && !abort) begin
      start_ok_s = 1'b1;
    end else begin
      start_ok_s = 1'b0;
    end
    if ((state_r == ST_RUN) && !abort && !end_hit_s && !wd_expire_s && !stall_hit_s) begin
      wd_enable_s = 1'b1;
    end else begin
      wd_enable_s = 1'b0;
    end
  end

  run_watchdog #(
    .W     (WDOG_W),
    .LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .CLK    (CLK),
    .resetl (resetl),
    .clear  (start_ok_s),
    .enable (wd_enable_s),
    .count  (cycles),
    .expire (wd_expire_s)
  );

  // Run sequencer: state, latched run parameters and all registered status outputs.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_r      <= ST_IDLE;
      rst_cnt_r    <= {RC_W{1'b0}};
      end_pc_r     <= {PC_W{1'b0}};
      exp_r        <= {PC_W{1'b0}};
      core_resetl  <= 1'b0;
      core_startpc <= {PC_W{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      result       <= {PC_W{1'b0}};
`ifdef PROC_RUN_STALL_DETECT_EN
      stall        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        state_r     <= ST_IDLE;
        core_resetl <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE, ST_DONE: begin
            core_resetl <= 1'b0;
            if (start) begin
              core_startpc <= start_pc_in;
              end_pc_r     <= end_pc_in;
              exp_r        <= expected_in;
              pass         <= 1'b0;
              timeout      <= 1'b0;
`ifdef PROC_RUN_STALL_DETECT_EN
              stall        <= 1'b0;
`endif
              rst_cnt_r    <= {RC_W{1'b0}};
              busy         <= 1'b1;
              state_r      <= ST_RESET;
            end else begin
              state_r <= state_r;
            end
          end
          ST_RESET: begin
            if (rst_cnt_r == RC_LAST) begin
              core_resetl <= 1'b1;
              state_r     <= ST_RUN;
            end else begin
              rst_cnt_r <= rst_cnt_r + RC_W'(1);
            end
          end
          ST_RUN: begin
            if (end_hit_s) begin
              result      <= memtoreg_in;
              pass        <= (memtoreg_in == exp_r);
              done        <= 1'b1;
              busy        <= 1'b0;
              core_resetl <= 1'b0;
              state_r     <= ST_DONE;
            end else if (wd_expire_s) begin
              result      <= memtoreg_in;
              pass        <= 1'b0;
              timeout     <= 1'b1;
              done        <= 1'b1;
              busy        <= 1'b0;
              core_resetl <= 1'b0;
              state_r     <= ST_DONE;
            end
`ifdef PROC_RUN_STALL_DETECT_EN
            else if (stall_hit_s) begin
              result      <= memtoreg_in;
              pass        <= 1'b0;
              stall       <= 1'b1;
              done        <= 1'b1;
              busy        <= 1'b0;
              core_resetl <= 1'b0;
              state_r     <= ST_DONE;
            end
`endif
            else begin
              state_r <= ST_RUN;
            end
          end
          default: begin
            state_r     <= ST_IDLE;
            core_resetl <= 1'b0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : proc_run_controller
